// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester frame encoder.
package manch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOF   = 2'd1,
        HALF1 = 2'd2,
        HALF2 = 2'd3
    } manch_state_t;

    localparam int MANCH_POL_IEEE   = 0;
    localparam int MANCH_POL_THOMAS = 1;

endpackage

// File: rtl/manch_enc_frame_if.sv
// Word input bus of the Manchester frame encoder.
interface manch_enc_frame_if #(
    parameter int DATA_W = 8
);

    // A word transfers on a rising clk edge where in_valid and in_ready are both
    // high; in_data is only sampled then. in_ready is combinational.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/manch_halfbit_timer.sv
// Half-bit period counter: half_tick marks the last cycle of each half-symbol,
// tick_next says the following cycle will be such a last cycle.
module manch_halfbit_timer #(
    parameter int HALF_BIT_CLKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic half_tick,
    output logic tick_next
);

    localparam int CW = $clog2(HALF_BIT_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CLKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        half_tick = run && (cnt_q == LAST);
        if (clear) begin
            cnt_d = '0;
        end else if (half_tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_next = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/manch_enc_frame.sv
// Manchester frame encoder: serialises handshaked words onto a registered line.
// Optional start-of-frame code violation is enabled with macro MANCH_SOF_EN.
module manch_enc_frame
    import manch_pkg::*;
#(
    parameter int   DATA_W        = 8,
    parameter int   HALF_BIT_CLKS = 4,
    parameter int   MSB_FIRST     = 1,
    parameter int   POLARITY      = 0,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_enable,
    manch_enc_frame_if.slave   bus,
    output logic               out_data,
    output logic               out_active,
    output logic               frame_done,
    output manch_state_t       dbg_state
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

`ifdef MANCH_SOF_EN
    localparam manch_state_t START_STATE = SOF;
`else
    localparam manch_state_t START_STATE = HALF1;
`endif

    manch_state_t      state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              out_data_q, out_data_d;
    logic              out_active_q, out_active_d;
    logic              frame_done_q, frame_done_d;
`ifdef MANCH_SOF_EN
    logic              sof_second_q, sof_second_d;
`endif

    logic half_tick;
    logic tick_next;
    logic last_cycle;
    logic accept;
    logic next_bit;
    logic first_half;

    manch_halfbit_timer #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((state_q == IDLE) || !in_enable),
        .run       (state_q != IDLE),
        .half_tick (half_tick),
        .tick_next (tick_next)
    );

    assign last_cycle   = (state_q == HALF2) && half_tick && (bit_q == '0);
    assign bus.in_ready = in_enable && ((state_q == IDLE) || last_cycle);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef MANCH_SOF_EN
        sof_second_d = sof_second_q;
`endif
        if (!in_enable) begin
            state_d = IDLE;
            bit_d   = '0;
            shift_d = '0;
`ifdef MANCH_SOF_EN
            sof_second_d = 1'b0;
`endif
        end else if (accept) begin
            state_d = START_STATE;
            bit_d   = LAST_BIT;
            shift_d = bus.in_data;
        end else begin
            unique case (state_q)
                IDLE: ;
`ifdef MANCH_SOF_EN
                SOF: begin
                    if (half_tick) begin
                        sof_second_d = !sof_second_q;
                        if (sof_second_q) state_d = HALF1;
                    end
                end
`endif
                HALF1: begin
                    if (half_tick) state_d = HALF2;
                end
                HALF2: begin
                    if (half_tick) begin
                        if (bit_q == '0) begin
                            state_d = IDLE;
                            shift_d = '0;
                        end else begin
                            state_d = HALF1;
                            bit_d   = bit_q - BW'(1);
                            shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered, so they are derived from the next-cycle state.
    always_comb begin
        next_bit     = (MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0];
        first_half   = (POLARITY == MANCH_POL_IEEE) ? !next_bit : next_bit;
        out_data_d   = IDLE_LEVEL;
        out_active_d = (state_d != IDLE);
        frame_done_d = (state_d == HALF2) && (bit_d == '0) && tick_next;
        case (state_d)
            SOF:     out_data_d = !IDLE_LEVEL;
            HALF1:   out_data_d = first_half;
            HALF2:   out_data_d = !first_half;
            default: out_data_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= IDLE_LEVEL;
            out_active_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_active_q <= out_active_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef MANCH_SOF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_second_q <= 1'b0;
        end else begin
            sof_second_q <= sof_second_d;
        end
    end
`endif

    assign out_data   = out_data_q;
    assign out_active = out_active_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_manch_enc_frame.sv
// Self-checking bench for manch_enc_frame: default DUT (IEEE, MSB first, 4 clk
// half-bits) plus a Thomas / LSB-first / 1 clk half-bit DUT.
module tb_manch_enc_frame;
    import manch_pkg::*;

    localparam int DW  = 8;
    localparam int H_A = 4;
    localparam int H_B = 1;
`ifdef MANCH_SOF_EN
    localparam int SOF_A = 2 * H_A;
    localparam int SOF_B = 2 * H_B;
`else
    localparam int SOF_A = 0;
    localparam int SOF_B = 0;
`endif
    localparam int LEN_A = SOF_A + DW * 2 * H_A;
    localparam int LEN_B = SOF_B + DW * 2 * H_B;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    always #5 clk = ~clk;

    manch_enc_frame_if #(.DATA_W(DW)) bus_a ();
    manch_enc_frame_if #(.DATA_W(DW)) bus_b ();

    logic a_data, a_act, a_done;
    logic b_data, b_act, b_done;
    manch_state_t a_state, b_state;

    manch_enc_frame #(
        .DATA_W(DW), .HALF_BIT_CLKS(H_A), .MSB_FIRST(1), .POLARITY(0), .IDLE_LEVEL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_enable(en), .bus(bus_a.slave),
        .out_data(a_data), .out_active(a_act), .frame_done(a_done), .dbg_state(a_state)
    );

    manch_enc_frame #(
        .DATA_W(DW), .HALF_BIT_CLKS(H_B), .MSB_FIRST(0), .POLARITY(1), .IDLE_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_enable(en), .bus(bus_b.slave),
        .out_data(b_data), .out_active(b_act), .frame_done(b_done), .dbg_state(b_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Symbol k of a frame as {line, active, done}, from the encoding rules alone.
    function automatic logic [2:0] frame_sym(input logic [7:0] w, input int k, input int h,
                                             input bit msb, input bit thomas, input int sofc);
        int len;
        int j;
        int bp;
        int sec;
        logic b;
        logic first;
        logic d;
        len = sofc + DW * 2 * h;
        if (k < sofc) begin
            d = 1'b1;
        end else begin
            j     = k - sofc;
            bp    = j / (2 * h);
            sec   = (j / h) % 2;
            b     = msb ? w[DW-1-bp] : w[bp];
            first = thomas ? b : !b;
            d     = (sec != 0) ? !first : first;
        end
        return {d, 1'b1, (k == len - 1)};
    endfunction

    logic [2:0] exp_a[$];
    logic [2:0] exp_b[$];
    logic [2:0] ea, eb;

    always @(posedge clk) begin
        if (!rst_n || !en) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (bus_a.in_valid && exp_a.size() == 0)
                for (int k = 0; k < LEN_A; k++) exp_a.push_back(frame_sym(bus_a.in_data, k, H_A, 1'b1, 1'b0, SOF_A));
            if (bus_b.in_valid && exp_b.size() == 0)
                for (int k = 0; k < LEN_B; k++) exp_b.push_back(frame_sym(bus_b.in_data, k, H_B, 1'b0, 1'b1, SOF_B));
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a.delete();
            exp_b.delete();
        end
        ea = (exp_a.size() != 0) ? exp_a.pop_front() : 3'b000;
        eb = (exp_b.size() != 0) ? exp_b.pop_front() : 3'b000;
        chk("sb_a_line", {a_data, a_act, a_done}, ea);
        chk("sb_a_ready", bus_a.in_ready, en && (exp_a.size() == 0));
        chk("sb_b_line", {b_data, b_act, b_done}, eb);
        chk("sb_b_ready", bus_b.in_ready, en && (exp_b.size() == 0));
    end

    // ---------------- driver tasks ----------------
    task automatic send_a(input logic [7:0] w);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w);
        @(posedge clk); #1;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = w;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  word;
        logic [15:0] line;
    } vec_t;

    vec_t tbl[6];
    logic [15:0] line_b;
    logic        exp_d;

    // ---------------- test ----------------
    initial begin
        tbl[0] = '{word: 8'hA5, line: 16'h6699};
        tbl[1] = '{word: 8'hFF, line: 16'h5555};
        tbl[2] = '{word: 8'h00, line: 16'hAAAA};
        tbl[3] = '{word: 8'h80, line: 16'h6AAA};
        tbl[4] = '{word: 8'h01, line: 16'hAAA9};
        tbl[5] = '{word: 8'h3C, line: 16'hA55A};

        bus_a.in_valid = 1'b0; bus_a.in_data = '0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_data", a_data, 1'b0);
        chk("rst_active", a_act, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_state_a", a_state, IDLE);
        chk("rst_state_b", b_state, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus_a.in_ready, 1'b1);

        // table-driven single words
        foreach (tbl[i]) begin
            send_a(tbl[i].word);
            for (int c = 1; c <= LEN_A; c++) begin
                @(negedge clk);
                exp_d = (c <= SOF_A) ? 1'b1 : tbl[i].line[15 - ((c - 1 - SOF_A) / H_A)];
                chk("tbl_data", a_data, exp_d);
                chk("tbl_active", a_act, 1'b1);
                chk("tbl_done", a_done, c == LEN_A);
            end
            @(negedge clk);
            chk("tbl_idle_active", a_act, 1'b0);
            chk("tbl_idle_data", a_data, 1'b0);
        end

        // back-to-back FF then 00
        @(posedge clk); #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'hFF;
        @(posedge clk); #1;
        bus_a.in_data  = 8'h00;
        for (int c = 1; c <= 2 * LEN_A; c++) begin
            @(negedge clk);
            chk("b2b_active", a_act, 1'b1);
            chk("b2b_done", a_done, (c == LEN_A) || (c == 2 * LEN_A));
            if (c == LEN_A - 1) chk("b2b_ready_early", bus_a.in_ready, 1'b0);
            if (c == LEN_A) begin
                chk("b2b_ready_last", bus_a.in_ready, 1'b1);
                @(posedge clk); #1;
                bus_a.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", a_act, 1'b0);

        // abort at cycle 20, word offered while disabled
        send_a(8'hA5);
        idle_cycles(19);
        @(posedge clk); #1;
        en = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h3C;
        @(negedge clk);
        chk("abort_ready_c20", bus_a.in_ready, 1'b0);
        for (int c = 21; c <= 30; c++) begin
            @(negedge clk);
            chk("abort_active", a_act, 1'b0);
            chk("abort_data", a_data, 1'b0);
            chk("abort_done", a_done, 1'b0);
            chk("abort_ready", bus_a.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("abort_ready_reen", bus_a.in_ready, 1'b1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        idle_cycles(LEN_A + 2);

        // enable fall together with a handshake in the final cycle
        @(posedge clk); #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h55;
        @(posedge clk); #1;
        bus_a.in_data  = 8'hAA;
        idle_cycles(LEN_A - 1);
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        chk("final_abort_ready", bus_a.in_ready, 1'b0);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk("final_abort_idle", a_act, 1'b0);
        @(posedge clk); #1;
        en = 1'b1;
        idle_cycles(3);

        // Thomas / LSB-first / 1 clk half-bit
        line_b = 16'h9555;
        send_b(8'h01);
        for (int c = 1; c <= LEN_B; c++) begin
            @(negedge clk);
            exp_d = (c <= SOF_B) ? 1'b1 : line_b[15 - ((c - 1 - SOF_B) / H_B)];
            chk("thomas_data", b_data, exp_d);
            chk("thomas_done", b_done, c == LEN_B);
        end
        @(negedge clk);
        chk("thomas_idle", b_act, 1'b0);

        // reset asserted mid-frame
        send_a(8'h5A);
        idle_cycles(9);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_active", a_act, 1'b0);
        chk("rst_mid_data", a_data, 1'b0);
        chk("rst_mid_done", a_done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(LEN_A + 4);

        // randomized traffic on both encoders
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            en             = ($urandom_range(0, 149) != 0);
            rst_n          = ($urandom_range(0, 699) != 0);
            bus_a.in_valid = ($urandom_range(0, 2) != 0);
            bus_a.in_data  = 8'($urandom);
            bus_b.in_valid = ($urandom_range(0, 3) == 0);
            bus_b.in_data  = 8'($urandom);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        idle_cycles(LEN_A + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
